// File: rtl/oric_mem_pkg.sv
// Shared types and constants for the Oric-to-SDRAM bridge.
package oric_mem_pkg;

   localparam int unsigned TIMEOUT_CYC_DFLT = 255;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned QW = 16;

   localparam logic [1:0] DS_LO   = 2'b01;
   localparam logic [1:0] DS_HI   = 2'b10;
   localparam logic [1:0] DS_WORD = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic [AW-1:0] a;
      logic          we;
      logic [QW-1:0] d;
      logic [1:0]    ds;
   } req_t;

   localparam req_t REQ_RST = '{a: '0, we: 1'b0, d: '0, ds: DS_WORD};

   // Byte lane of a write follows the address LSB.
   function automatic logic [1:0] wr_ds(input logic a0);
      return a0 ? DS_HI : DS_LO;
   endfunction

endpackage

// File: rtl/oric_sdram_bridge_if.sv
// Oric core bus plus toggle-handshake SDRAM port, as seen by the bridge.
interface oric_sdram_bridge_if;
   import oric_mem_pkg::*;

   logic          ram_cs;
   logic          ram_oe;
   logic          ram_we;
   logic [AW-1:0] ram_ad;
   logic [DW-1:0] ram_d;
   logic [DW-1:0] ram_q;
   logic          port_req;
   logic          port_ack;
   logic [AW-1:0] port_a;
   logic [1:0]    port_ds;
   logic          port_we;
   logic [QW-1:0] port_d;
   logic [QW-1:0] port_q;
   logic          busy;
   logic          ovf;
   logic          err;

   modport master (
      output ram_cs, ram_oe, ram_we, ram_ad, ram_d, port_ack, port_q,
      input  ram_q, port_req, port_a, port_ds, port_we, port_d, busy, ovf, err
   );

   modport slave (
      input  ram_cs, ram_oe, ram_we, ram_ad, ram_d, port_ack, port_q,
      output ram_q, port_req, port_a, port_ds, port_we, port_d, busy, ovf, err
   );

endinterface

// File: rtl/oric_mem_evt_detect.sv
// Turns the level-style Oric strobes into single-cycle read/write events.
module oric_mem_evt_detect
   import oric_mem_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          ram_cs,
   input  logic          ram_oe,
   input  logic          ram_we,
   input  logic [AW-1:0] ram_ad,
   output logic          rd_evt,
   output logic          wr_evt
);

   logic          rd_en;
   logic          wr_en;
   logic [AW-1:0] ad_prev_q, ad_prev_d;
   logic          rd_prev_q, rd_prev_d;
   logic          wr_prev_q, wr_prev_d;

   // A held read strobe retriggers whenever the address moves.
   always_comb begin
      rd_en     = ram_cs & ram_oe;
      wr_en     = ram_cs & ram_we;
      ad_prev_d = ram_ad;
      rd_prev_d = rd_en;
      wr_prev_d = wr_en;
      rd_evt    = (rd_en & ~rd_prev_q) | (rd_en & (ram_ad != ad_prev_q));
      wr_evt    = wr_en & ~wr_prev_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ad_prev_q <= '0;
         rd_prev_q <= 1'b0;
         wr_prev_q <= 1'b0;
      end else begin
         ad_prev_q <= ad_prev_d;
         rd_prev_q <= rd_prev_d;
         wr_prev_q <= wr_prev_d;
      end
   end

endmodule

// File: rtl/oric_sdram_bridge.sv
// Bridges Oric bus cycles onto a toggle req/ack SDRAM port with a one-deep
// pending slot, an abandon-on-timeout watchdog and a sticky error flag.
module oric_sdram_bridge
   import oric_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
   input  logic               clk,
   input  logic               reset,
   oric_sdram_bridge_if.slave bus
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic          rd_evt;
   logic          wr_evt;
   logic          evt;
   logic          done;
   logic          launch;
   req_t          new_req;
   req_t          launch_req;

   state_e        state_q, state_d;
   req_t          cur_q, cur_d;
   req_t          pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic          port_req_q, port_req_d;
   logic [DW-1:0] ram_q_q, ram_q_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d;

   oric_mem_evt_detect u_evt (
      .clk    (clk),
      .reset  (reset),
      .ram_cs (bus.ram_cs),
      .ram_oe (bus.ram_oe),
      .ram_we (bus.ram_we),
      .ram_ad (bus.ram_ad),
      .rd_evt (rd_evt),
      .wr_evt (wr_evt)
   );

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      port_req_d = port_req_q;
      ram_q_d    = ram_q_q;
      busy_d     = busy_q;
      ovf_d      = 1'b0;
      err_d      = err_q;
      tmo_d      = tmo_q;
      launch     = 1'b0;

      // A coincident read and write strobe collapses into the write.
      evt        = rd_evt | wr_evt;
      new_req.a  = bus.ram_ad;
      new_req.we = wr_evt;
      new_req.d  = {bus.ram_d, bus.ram_d};
      new_req.ds = wr_evt ? wr_ds(bus.ram_ad[0]) : DS_WORD;
      launch_req = new_req;
      done       = (bus.port_ack == port_req_q);

      case (state_q)
         ST_IDLE: begin
            if (evt) begin
               launch  = 1'b1;
               state_d = ST_WAIT;
               busy_d  = 1'b1;
            end
         end
         ST_WAIT: begin
            if (done) begin
               if (!cur_q.we) begin
                  ram_q_d = cur_q.a[0] ? bus.port_q[15:8] : bus.port_q[7:0];
               end
               // Older pending request goes first; a fresh event takes its slot.
               if (pend_vld_q) begin
                  launch     = 1'b1;
                  launch_req = pend_q;
                  pend_d     = new_req;
                  pend_vld_d = evt;
               end else if (evt) begin
                  launch = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               // Abandon: realign req with ack so the port sees nothing outstanding.
               err_d      = 1'b1;
               pend_vld_d = 1'b0;
               port_req_d = bus.port_ack;
               state_d    = ST_IDLE;
               busy_d     = 1'b0;
               tmo_d      = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (evt) begin
                  pend_d     = new_req;
                  pend_vld_d = 1'b1;
                  ovf_d      = pend_vld_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (launch) begin
         cur_d      = launch_req;
         port_req_d = ~port_req_q;
         tmo_d      = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cur_q      <= REQ_RST;
         pend_q     <= REQ_RST;
         pend_vld_q <= 1'b0;
         port_req_q <= 1'b0;
         ram_q_q    <= '0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         port_req_q <= port_req_d;
         ram_q_q    <= ram_q_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
      end
   end

   assign bus.ram_q    = ram_q_q;
   assign bus.port_req = port_req_q;
   assign bus.port_a   = cur_q.a;
   assign bus.port_ds  = cur_q.ds;
   assign bus.port_we  = cur_q.we;
   assign bus.port_d   = cur_q.d;
   assign bus.busy     = busy_q;
   assign bus.ovf      = ovf_q;
   assign bus.err      = err_q;

endmodule
